// File: rtl/rrp_otf_convert_pkg.sv
// rrp_otf_convert_pkg: types and helpers shared by the on-the-fly converter
// and its single-digit update step.
//   state_t   converter FSM states (IDLE/CONV/DONE)
//   digit_w   signed-digit width for a radix: clog2(radix)+1
//   digit_max / digit_min  legal digit range [-(radix-1), radix-1]
//   err_digit the out-of-range digit -radix (pattern 100..0)
package rrp_otf_convert_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int digit_w(input int radix);
        return $clog2(radix) + 1;
    endfunction

    function automatic int digit_max(input int radix);
        return radix - 1;
    endfunction

    function automatic int digit_min(input int radix);
        return -(radix - 1);
    endfunction

    function automatic int err_digit(input int radix);
        return -radix;
    endfunction

endpackage

// File: rtl/rrp_otf_convert_step.sv
// rrp_otf_convert_step: combinational single-digit on-the-fly update.
//   q        signed digit being appended (D bits)
//   q_cur    current value Q (OUT_W bits, mod 2^OUT_W)
//   qm_cur   current value QM = Q - 1
//   q_next   Q' after appending q
//   qm_next  QM' after appending q
module rrp_otf_convert_step
    import rrp_otf_convert_pkg::*;
#(
    parameter int RADIX = 2,
    parameter int WIDTH = 6,
    localparam int K     = $clog2(RADIX),
    localparam int D     = digit_w(RADIX),
    localparam int OUT_W = K * WIDTH + 1
) (
    input  logic signed [D-1:0]     q,
    input  logic        [OUT_W-1:0] q_cur,
    input  logic        [OUT_W-1:0] qm_cur,
    output logic        [OUT_W-1:0] q_next,
    output logic        [OUT_W-1:0] qm_next
);

    localparam logic [OUT_W-1:0] R   = OUT_W'(RADIX);
    localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

    logic [OUT_W-1:0] qx;
    logic [OUT_W-1:0] q_sh;
    logic [OUT_W-1:0] qm_sh;
    logic             q_neg;
    logic             q_pos;

    always_comb begin
        qx    = OUT_W'(q);      // sign-extended digit
        q_sh  = q_cur << K;
        qm_sh = qm_cur << K;
        q_neg = q[D-1];
        q_pos = !q[D-1] && (q != '0);

        // Negative digits borrow from QM so no carry ever propagates.
        if (!q_neg) q_next = q_sh + qx;
        else        q_next = qm_sh + R + qx;

        if (q_pos) qm_next = q_sh + qx - ONE;
        else       qm_next = qm_sh + R - ONE + qx;
    end

endmodule

// File: rtl/rrp_otf_convert.sv
// rrp_otf_convert: MSDF digit-serial on-the-fly converter, redundant
// signed-digit words (MSD first, WIDTH digits) -> two's complement.
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_digit   signed digit (D bits), in_valid / in_ready handshake
//   out_value  signed result (OUT_W bits), out_valid / out_ready handshake
//   out_err    word contained the out-of-range digit -RADIX
// Optional (macro RRP_OTF_EARLY_SIGN_EN):
//   sign_valid first nonzero digit of the current word has been accepted
//   sign       sign of that digit (1 = negative)
module rrp_otf_convert
    import rrp_otf_convert_pkg::*;
#(
    parameter int RADIX = 2,
    parameter int WIDTH = 6,
    localparam int K     = $clog2(RADIX),
    localparam int D     = digit_w(RADIX),
    localparam int OUT_W = K * WIDTH + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [D-1:0]     in_digit,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] out_value,
    output logic                    out_err,
    output logic                    out_valid,
`ifdef RRP_OTF_EARLY_SIGN_EN
    output logic                    sign_valid,
    output logic                    sign,
`endif
    input  logic                    out_ready
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [D-1:0] ERR_PAT = D'(err_digit(RADIX));

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [OUT_W-1:0] q_reg;
    logic [OUT_W-1:0] qm_reg;
    logic [OUT_W-1:0] q_next;
    logic [OUT_W-1:0] qm_next;
    logic [OUT_W-1:0] value_reg;
    logic             err_reg;
    logic             accept;
    logic             last;
    logic             first;
    logic             is_err;

    rrp_otf_convert_step #(
        .RADIX(RADIX),
        .WIDTH(WIDTH)
    ) u_step (
        .q      (in_digit),
        .q_cur  (q_reg),
        .qm_cur (qm_reg),
        .q_next (q_next),
        .qm_next(qm_next)
    );

    always_comb begin
        in_ready   = (state != DONE);
        out_valid  = (state == DONE);
        accept     = in_valid && in_ready;
        last       = (cnt == CW'(WIDTH - 1));
        first      = (cnt == '0);
        is_err     = (in_digit == ERR_PAT);
        state_next = state;
        case (state)
            IDLE, CONV: begin
                if (accept) state_next = last ? DONE : CONV;
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Q/QM return to 0/-1 at word end so the next word's first digit
    // needs no special-case select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            q_reg     <= '0;
            qm_reg    <= '1;
            value_reg <= '0;
            err_reg   <= 1'b0;
        end else if (accept) begin
            if (last) begin
                cnt       <= '0;
                q_reg     <= '0;
                qm_reg    <= '1;
                value_reg <= q_next;
            end else begin
                cnt    <= cnt + 1'b1;
                q_reg  <= q_next;
                qm_reg <= qm_next;
            end
            err_reg <= (first ? 1'b0 : err_reg) | is_err;
        end
    end

    always_comb begin
        out_value = value_reg;
        out_err   = err_reg;
    end

`ifdef RRP_OTF_EARLY_SIGN_EN
    logic sv_reg;
    logic sign_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sv_reg   <= 1'b0;
            sign_reg <= 1'b0;
        end else if (out_valid && out_ready) begin
            sv_reg   <= 1'b0;
            sign_reg <= 1'b0;
        end else if (accept && !sv_reg && (in_digit != '0)) begin
            sv_reg   <= 1'b1;
            sign_reg <= in_digit[D-1];
        end
    end

    always_comb begin
        sign_valid = sv_reg;
        sign       = sign_reg;
    end
`endif

endmodule

// File: tb/tb_rrp_otf_convert.sv
module tb_rrp_otf_convert;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // DUT A: RADIX=2, WIDTH=6 (D=2, OUT_W=7)
    logic signed [1:0] a_digit;
    logic              a_valid, a_ready, a_err, a_ovalid, a_oready;
    logic signed [6:0] a_value;
    // DUT B: RADIX=4, WIDTH=4 (D=3, OUT_W=9)
    logic signed [2:0] b_digit;
    logic              b_valid, b_ready, b_err, b_ovalid, b_oready;
    logic signed [8:0] b_value;
`ifdef RRP_OTF_EARLY_SIGN_EN
    logic a_sv, a_sign, b_sv, b_sign;
`endif

    rrp_otf_convert #(.RADIX(2), .WIDTH(6)) u_dut_a (
        .clk(clk), .rst(rst), .in_digit(a_digit), .in_valid(a_valid), .in_ready(a_ready),
        .out_value(a_value), .out_err(a_err), .out_valid(a_ovalid),
`ifdef RRP_OTF_EARLY_SIGN_EN
        .sign_valid(a_sv), .sign(a_sign),
`endif
        .out_ready(a_oready)
    );

    rrp_otf_convert #(.RADIX(4), .WIDTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .in_digit(b_digit), .in_valid(b_valid), .in_ready(b_ready),
        .out_value(b_value), .out_err(b_err), .out_valid(b_ovalid),
`ifdef RRP_OTF_EARLY_SIGN_EN
        .sign_valid(b_sv), .sign(b_sign),
`endif
        .out_ready(b_oready)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        string nm;
        int    dg[6];
        int    val;
        bit    err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm, input int d0, input int d1, input int d2,
                       input int d3, input int d4, input int d5, input int v, input bit e);
        vec_t t;
        t.nm = nm;
        t.dg[0] = d0; t.dg[1] = d1; t.dg[2] = d2;
        t.dg[3] = d3; t.dg[4] = d4; t.dg[5] = d5;
        t.val = v;
        t.err = e;
        tbl.push_back(t);
    endtask

    // Sends one word on DUT A; checks out_valid timing and early sign per digit.
    task automatic a_word(input int dg[6], input int max_gap);
        int n;
        int g;
        bit seen;
        bit sgn;
        seen = 0;
        sgn  = 0;
        for (int i = 0; i < 6; i++) begin
            g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            repeat (g) begin
                a_valid = 0;
                @(posedge clk); #1;
            end
            a_valid = 1;
            a_digit = 2'(dg[i]);
            n = 0;
            while (!a_ready && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 50) chk("a_ready_timeout", 0, 1);
            @(posedge clk); #1;
            a_valid = 0;
            chk("a_out_valid_timing", a_ovalid, (i == 5));
`ifdef RRP_OTF_EARLY_SIGN_EN
            if (!seen && dg[i] != 0) begin
                seen = 1;
                sgn  = (dg[i] < 0);
            end
            chk("a_sign_valid", a_sv, seen);
            if (seen) chk("a_sign", a_sign, sgn);
`endif
        end
    endtask

    task automatic a_expect(input string nm, input int v, input bit e);
        logic signed [6:0] t;
        t = 7'(v);
        chk({nm, "_out_valid"}, a_ovalid, 1);
        chk({nm, "_value"}, a_value, t);
        chk({nm, "_err"}, a_err, e);
        a_oready = 1;
        @(posedge clk); #1;
        a_oready = 0;
        chk({nm, "_released"}, a_ovalid, 0);
`ifdef RRP_OTF_EARLY_SIGN_EN
        chk({nm, "_sign_cleared"}, a_sv, 0);
`endif
    endtask

    task automatic b_word(input int dg[4], input int max_gap);
        int n;
        int g;
        bit seen;
        bit sgn;
        seen = 0;
        sgn  = 0;
        for (int i = 0; i < 4; i++) begin
            g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            repeat (g) begin
                b_valid = 0;
                @(posedge clk); #1;
            end
            b_valid = 1;
            b_digit = 3'(dg[i]);
            n = 0;
            while (!b_ready && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 50) chk("b_ready_timeout", 0, 1);
            @(posedge clk); #1;
            b_valid = 0;
            chk("b_out_valid_timing", b_ovalid, (i == 3));
`ifdef RRP_OTF_EARLY_SIGN_EN
            if (!seen && dg[i] != 0) begin
                seen = 1;
                sgn  = (dg[i] < 0);
            end
            chk("b_sign_valid", b_sv, seen);
            if (seen) chk("b_sign", b_sign, sgn);
`endif
        end
    endtask

    task automatic b_expect(input int v, input bit e);
        logic signed [8:0] t;
        int h;
        t = 9'(v);
        h = $urandom_range(0, 3);
        chk("b_out_valid", b_ovalid, 1);
        chk("b_value", b_value, t);
        chk("b_err", b_err, e);
        repeat (h) begin
            b_valid = 1;
            b_digit = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
            b_valid = 0;
            chk("b_hold_value", b_value, t);
            chk("b_hold_in_ready", b_ready, 0);
        end
        b_oready = 1;
        @(posedge clk); #1;
        b_oready = 0;
        chk("b_released", b_ovalid, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dg6[6];
        int dg4[4];
        int v;
        bit e;
        int r;

        rst = 1;
        a_valid = 0; a_digit = '0; a_oready = 0;
        b_valid = 0; b_digit = '0; b_oready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a_out_valid", a_ovalid, 0);
        chk("reset_a_value", a_value, 0);
        chk("reset_a_err", a_err, 0);
        chk("reset_b_out_valid", b_ovalid, 0);
        rst = 0;
        #1;
        chk("reset_a_in_ready", a_ready, 1);
        chk("reset_b_in_ready", b_ready, 1);

        add("t1_mixed",      1, 0, -1, 0, 0, 1,  25, 0);
        add("t2_all_neg",   -1, -1, -1, -1, -1, -1, -63, 0);
        add("t2_zero",       0, 0, 0, 0, 0, 0,   0, 0);
        add("t5_err_digit",  0, 0, 0, 0, 0, -2, -2, 1);
        add("t5_clean",      1, -1, 1, -1, 1, -1, 21, 0);
        add("t6_sign",       0, 0, -1, 1, 1, 1, -1, 0);
        add("all_pos",       1, 1, 1, 1, 1, 1,  63, 0);
        add("lead_neg",     -1, 1, 1, 1, 1, 1, -1, 0);

        foreach (tbl[i]) begin
            a_word(tbl[i].dg, 0);
            a_expect(tbl[i].nm, tbl[i].val, tbl[i].err);
        end

        // Hold in DONE with out_ready low; extra digits must be ignored.
        dg6 = '{1, 1, 0, 0, 0, -1};
        a_word(dg6, 0);
        repeat (3) begin
            a_valid = 1;
            a_digit = 2'sd1;
            @(posedge clk); #1;
            chk("t3_hold_value", a_value, 7'sd47);
            chk("t3_hold_in_ready", a_ready, 0);
            chk("t3_hold_out_valid", a_ovalid, 1);
        end
        a_valid = 0;
        a_expect("t3_release", 47, 0);
        dg6 = '{0, 0, 0, 0, 0, 1};
        a_word(dg6, 0);
        a_expect("t3_after", 1, 0);

        // Reset mid-word discards the partial word.
        for (int i = 0; i < 3; i++) begin
            a_valid = 1;
            a_digit = 2'sd1;
            @(posedge clk); #1;
        end
        a_valid = 0;
        rst = 1;
        #2;
        chk("t4_rst_out_valid", a_ovalid, 0);
        chk("t4_rst_value", a_value, 0);
        rst = 0;
        dg6 = '{1, 1, 1, 1, 1, 1};
        a_word(dg6, 0);
        a_expect("t4_after_rst", 63, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("t4_no_stale", a_ovalid, 0);
        end

        // Randomized DUT A words with input gaps, against an integer model.
        for (int w = 0; w < 30; w++) begin
            v = 0;
            e = 0;
            for (int i = 0; i < 6; i++) begin
                r = $urandom_range(0, 9);
                dg6[i] = (r == 0) ? -2 : (r % 3) - 1;
                v = v * 2 + dg6[i];
                if (dg6[i] == -2) e = 1;
            end
            a_word(dg6, 2);
            a_expect("rand_a", v, e);
        end

        // Randomized DUT B (RADIX=4, WIDTH=4) with gaps and output stalls.
        for (int w = 0; w < 40; w++) begin
            v = 0;
            e = 0;
            for (int i = 0; i < 4; i++) begin
                r = $urandom_range(0, 13);
                dg4[i] = (r == 0) ? -4 : (r % 7) - 3;
                v = v * 4 + dg4[i];
                if (dg4[i] == -4) e = 1;
            end
            b_word(dg4, 2);
            b_expect(v, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
